// File: rtl/agc_pkg.sv
// Shared constants for the AGC loop: state encoding and the widths
// that must agree with the error/integrator block.
package agc_pkg;

   localparam int AGC_BWIDTH   = 13;
   localparam int AGC_OUTWIDTH = 48;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACQUIRE = 2'd1;
   localparam logic [1:0] ST_TRACK   = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;

endpackage

// File: rtl/agc_gain_clamp.sv
// Registered shift-and-saturate: signed accumulator to unsigned gain word.
// Because the limits are zero-extended before the compare, any negative
// shifted value falls below gain_min and is clamped there.
module agc_gain_clamp #(
   parameter int OUTWIDTH = 48,
   parameter int GWIDTH   = 16,
   parameter int SHIFT    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid,
   input  logic signed [OUTWIDTH-1:0] acc,
   input  logic        [GWIDTH-1:0]   gain_min,
   input  logic        [GWIDTH-1:0]   gain_max,
   output logic        [GWIDTH-1:0]   gain,
   output logic                       gain_valid,
   output logic                       sat
);

   logic signed [OUTWIDTH-1:0] g;
   logic signed [OUTWIDTH-1:0] min_ext;
   logic signed [OUTWIDTH-1:0] max_ext;

   assign g       = acc >>> SHIFT;
   assign min_ext = $signed({{(OUTWIDTH-GWIDTH){1'b0}}, gain_min});
   assign max_ext = $signed({{(OUTWIDTH-GWIDTH){1'b0}}, gain_max});

   // Clamp and register the gain word whenever an accumulator update arrives
   always_ff @(posedge clk) begin
      if (rst) begin
         gain       <= '0;
         gain_valid <= 1'b0;
         sat        <= 1'b0;
      end else begin
         gain_valid <= valid;
         if (valid) begin
            if (g < min_ext) begin
               gain <= gain_min;
               sat  <= 1'b1;
            end else if (g > max_ext) begin
               gain <= gain_max;
               sat  <= 1'b1;
            end else begin
               gain <= g[GWIDTH-1:0];
               sat  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/agc_loop_ctrl.sv
// AGC loop sequencer: gates samples into the error block, selects the
// loop coefficient, detects lock/unlock from accumulator steps and
// produces the clamped gain word.
//
// state   | meaning
// IDLE    | loop off, coefficient 0, no samples forwarded
// ACQUIRE | fast coefficient, counting settled updates toward lock
// TRACK   | slow coefficient, locked, counting disturbed updates
// HOLD    | frozen, returns to the state held before entry
module agc_loop_ctrl
   import agc_pkg::*;
#(
   parameter int BWIDTH      = AGC_BWIDTH,
   parameter int OUTWIDTH    = AGC_OUTWIDTH,
   parameter int GWIDTH      = 16,
   parameter int SHIFT       = 16,
   parameter int TWIDTH      = 24,
   parameter int LOCK_CNT    = 64,
   parameter int UNLOCK_CNT  = 8,
   parameter int CWIDTH      = 16,
   parameter int ACQ_TIMEOUT = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       hold,
   input  logic                       sample_valid,
   input  logic        [BWIDTH-1:0]   acq_coeff,
   input  logic        [BWIDTH-1:0]   trk_coeff,
   input  logic        [TWIDTH-1:0]   lock_thresh,
   input  logic        [TWIDTH-1:0]   unlock_thresh,
   input  logic        [GWIDTH-1:0]   gain_min,
   input  logic        [GWIDTH-1:0]   gain_max,
   input  logic signed [OUTWIDTH-1:0] err_in,
   input  logic                       err_valid_in,
   output logic                       err_valid_out,
   output logic        [BWIDTH-1:0]   coeff_out,
   output logic        [GWIDTH-1:0]   gain_out,
   output logic                       gain_valid,
   output logic                       locked,
   output logic                       sat,
   output logic                       acq_timeout,
   output logic        [1:0]          state_out
);

   localparam logic [CWIDTH-1:0] LOCK_CNT_C    = CWIDTH'(LOCK_CNT);
   localparam logic [CWIDTH-1:0] UNLOCK_CNT_C  = CWIDTH'(UNLOCK_CNT);
   localparam logic [CWIDTH-1:0] ACQ_TIMEOUT_C = CWIDTH'(ACQ_TIMEOUT);

   logic [1:0]                 state;
   logic [1:0]                 state_nxt;
   logic [1:0]                 ret_state;
   logic                       upd_pend;
   logic                       first_upd;
   logic signed [OUTWIDTH-1:0] prev;
   logic signed [OUTWIDTH:0]   delta;
   logic        [OUTWIDTH:0]   delta_abs;
   logic                       settled;
   logic                       disturbed;
   logic                       upd_in_acq;
   logic                       upd_acq;
   logic                       upd_trk;
   logic                       lock_hit;
   logic                       unlock_hit;
   logic [CWIDTH-1:0]          lock_run;
   logic [CWIDTH-1:0]          unlock_run;
   logic [CWIDTH-1:0]          acq_upd;
   logic [CWIDTH-1:0]          lock_run_inc;
   logic [CWIDTH-1:0]          unlock_run_inc;
   logic [CWIDTH-1:0]          acq_upd_inc;

   // err_in is valid the cycle after err_valid_in, so upd_pend marks the update
   assign delta     = $signed({err_in[OUTWIDTH-1], err_in}) - $signed({prev[OUTWIDTH-1], prev});
   assign delta_abs = delta[OUTWIDTH] ? $unsigned(-delta) : $unsigned(delta);
   assign settled   = delta_abs <= {{(OUTWIDTH+1-TWIDTH){1'b0}}, lock_thresh};
   assign disturbed = delta_abs >= {{(OUTWIDTH+1-TWIDTH){1'b0}}, unlock_thresh};

   assign upd_in_acq = upd_pend && (state == ST_ACQUIRE);
   assign upd_acq    = upd_in_acq && !first_upd;
   assign upd_trk    = upd_pend && (state == ST_TRACK);

   assign lock_run_inc   = (&lock_run)   ? lock_run   : lock_run   + CWIDTH'(1);
   assign unlock_run_inc = (&unlock_run) ? unlock_run : unlock_run + CWIDTH'(1);
   assign acq_upd_inc    = (&acq_upd)    ? acq_upd    : acq_upd    + CWIDTH'(1);

   assign lock_hit   = upd_acq && settled   && (lock_run_inc   >= LOCK_CNT_C);
   assign unlock_hit = upd_trk && disturbed && (unlock_run_inc >= UNLOCK_CNT_C);

   assign locked    = (state == ST_TRACK);
   assign state_out = state;

   // Next-state decision: enable low wins, then hold, then lock/unlock runs
   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    state_nxt = ST_ACQUIRE;
            ST_ACQUIRE: begin
               if (hold)          state_nxt = ST_HOLD;
               else if (lock_hit) state_nxt = ST_TRACK;
            end
            ST_TRACK: begin
               if (hold)            state_nxt = ST_HOLD;
               else if (unlock_hit) state_nxt = ST_ACQUIRE;
            end
            default: begin
               if (!hold) state_nxt = ret_state;
            end
         endcase
      end
   end

   // State, update tracking, run counters and the sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ret_state   <= ST_IDLE;
         upd_pend    <= 1'b0;
         first_upd   <= 1'b1;
         prev        <= '0;
         lock_run    <= '0;
         unlock_run  <= '0;
         acq_upd     <= '0;
         acq_timeout <= 1'b0;
      end else begin
         state    <= state_nxt;
         upd_pend <= err_valid_in;

         if ((state_nxt == ST_HOLD) && (state != ST_HOLD))
            ret_state <= state;

         if (upd_pend && ((state == ST_ACQUIRE) || (state == ST_TRACK)))
            prev <= err_in;

         if (state_nxt == ST_IDLE)
            first_upd <= 1'b1;
         else if (upd_in_acq)
            first_upd <= 1'b0;

         if (state_nxt != state) begin
            lock_run   <= '0;
            unlock_run <= '0;
         end else begin
            if (upd_acq) lock_run   <= settled   ? lock_run_inc   : '0;
            if (upd_trk) unlock_run <= disturbed ? unlock_run_inc : '0;
         end

         // Timeout budget restarts with each fresh acquisition, not after HOLD
         if ((state_nxt == ST_IDLE) || ((state == ST_TRACK) && (state_nxt == ST_ACQUIRE)))
            acq_upd <= '0;
         else if (upd_in_acq)
            acq_upd <= acq_upd_inc;

         if (state_nxt == ST_IDLE)
            acq_timeout <= 1'b0;
         else if (upd_in_acq && (acq_upd_inc >= ACQ_TIMEOUT_C))
            acq_timeout <= 1'b1;
      end
   end

   // Sample gate and coefficient follow the upcoming state so they move together
   always_ff @(posedge clk) begin
      if (rst) begin
         err_valid_out <= 1'b0;
         coeff_out     <= '0;
      end else begin
         err_valid_out <= sample_valid &&
                          ((state_nxt == ST_ACQUIRE) || (state_nxt == ST_TRACK));
         case (state_nxt)
            ST_ACQUIRE: coeff_out <= acq_coeff;
            ST_TRACK:   coeff_out <= trk_coeff;
            ST_IDLE:    coeff_out <= '0;
            default:    coeff_out <= coeff_out;
         endcase
      end
   end

   agc_gain_clamp #(
      .OUTWIDTH (OUTWIDTH),
      .GWIDTH   (GWIDTH),
      .SHIFT    (SHIFT)
   ) u_gain_clamp (
      .clk        (clk),
      .rst        (rst),
      .valid      (upd_pend),
      .acc        (err_in),
      .gain_min   (gain_min),
      .gain_max   (gain_max),
      .gain       (gain_out),
      .gain_valid (gain_valid),
      .sat        (sat)
   );

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Directed bench for agc_loop_ctrl: clamp vector table plus hand-built
// acquire/track/hold/timeout/reset sequences.
module tb_agc_loop_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        hold;
   logic        sample_valid;
   logic [12:0] acq_coeff;
   logic [12:0] trk_coeff;
   logic [23:0] lock_thresh;
   logic [23:0] unlock_thresh;
   logic [15:0] gain_min;
   logic [15:0] gain_max;
   logic [47:0] err_in;
   logic        err_valid_in;
   logic        err_valid_out;
   logic [12:0] coeff_out;
   logic [15:0] gain_out;
   logic        gain_valid;
   logic        locked;
   logic        sat;
   logic        acq_timeout;
   logic [1:0]  state_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [47:0] err;
      logic [15:0] gmin;
      logic [15:0] gmax;
      logic [15:0] exp_gain;
      logic        exp_sat;
   } clamp_vec_t;

   clamp_vec_t vecs[8];

   localparam logic [12:0] ACQ_C = 13'h0AB;
   localparam logic [12:0] TRK_C = 13'h012;

   agc_loop_ctrl #(
      .LOCK_CNT    (4),
      .UNLOCK_CNT  (8),
      .ACQ_TIMEOUT (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .hold          (hold),
      .sample_valid  (sample_valid),
      .acq_coeff     (acq_coeff),
      .trk_coeff     (trk_coeff),
      .lock_thresh   (lock_thresh),
      .unlock_thresh (unlock_thresh),
      .gain_min      (gain_min),
      .gain_max      (gain_max),
      .err_in        (err_in),
      .err_valid_in  (err_valid_in),
      .err_valid_out (err_valid_out),
      .coeff_out     (coeff_out),
      .gain_out      (gain_out),
      .gain_valid    (gain_valid),
      .locked        (locked),
      .sat           (sat),
      .acq_timeout   (acq_timeout),
      .state_out     (state_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // valid strobe, then the accumulator value on the following cycle
   task automatic do_update(input logic [47:0] val);
      err_valid_in = 1'b1;
      tick();
      err_valid_in = 1'b0;
      err_in       = val;
      tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " state"},    64'(state_out),     64'd0);
      chk({tag, " coeff"},    64'(coeff_out),     64'd0);
      chk({tag, " evo"},      64'(err_valid_out), 64'd0);
      chk({tag, " gain"},     64'(gain_out),      64'd0);
      chk({tag, " gvalid"},   64'(gain_valid),    64'd0);
      chk({tag, " locked"},   64'(locked),        64'd0);
      chk({tag, " sat"},      64'(sat),           64'd0);
      chk({tag, " timeout"},  64'(acq_timeout),   64'd0);
   endtask

   logic [47:0] v;

   initial begin
      vecs[0] = '{48'h0000_4000_0000, 16'h0100, 16'h8000, 16'h4000, 1'b0};
      vecs[1] = '{48'hFFFF_FFFF_FFFF, 16'h0100, 16'h8000, 16'h0100, 1'b1};
      vecs[2] = '{48'h0001_0000_0000, 16'h0100, 16'h8000, 16'h8000, 1'b1};
      vecs[3] = '{48'h0000_0100_0000, 16'h0100, 16'h8000, 16'h0100, 1'b0};
      vecs[4] = '{48'h0000_8000_0000, 16'h0100, 16'h8000, 16'h8000, 1'b0};
      vecs[5] = '{48'h0000_00FF_FFFF, 16'h0100, 16'h8000, 16'h0100, 1'b1};
      vecs[6] = '{48'h0000_1234_FFFF, 16'h0100, 16'h8000, 16'h1234, 1'b0};
      vecs[7] = '{48'h8000_0000_0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1};

      rst = 1'b1; enable = 1'b0; hold = 1'b0; sample_valid = 1'b0;
      acq_coeff = ACQ_C; trk_coeff = TRK_C;
      lock_thresh = 24'd0; unlock_thresh = 24'd500;
      gain_min = 16'h0100; gain_max = 16'h8000;
      err_in = '0; err_valid_in = 1'b0;
      tick(); tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();
      chk("idle state", 64'(state_out), 64'd0);

      // gain clamp table, exercised while IDLE
      for (int i = 0; i < 8; i++) begin
         gain_min = vecs[i].gmin;
         gain_max = vecs[i].gmax;
         do_update(vecs[i].err);
         chk($sformatf("clamp%0d gain", i),   64'(gain_out),   64'(vecs[i].exp_gain));
         chk($sformatf("clamp%0d sat", i),    64'(sat),        64'(vecs[i].exp_sat));
         chk($sformatf("clamp%0d gvalid", i), 64'(gain_valid), 64'd1);
      end
      tick();
      chk("gvalid one-shot", 64'(gain_valid), 64'd0);
      gain_min = 16'h0100; gain_max = 16'h8000;

      // enable: ACQUIRE, fast coefficient, sample gate
      sample_valid = 1'b1; enable = 1'b1;
      tick();
      chk("acq state", 64'(state_out),     64'd1);
      chk("acq coeff", 64'(coeff_out),     64'(ACQ_C));
      chk("acq evo",   64'(err_valid_out), 64'd1);
      sample_valid = 1'b0;
      tick();
      chk("evo drop",  64'(err_valid_out), 64'd0);
      sample_valid = 1'b1;
      tick();
      chk("evo rise",  64'(err_valid_out), 64'd1);

      // lock: first update only loads prev, then 4 settled updates
      v = 48'h0000_1000_0000;
      for (int k = 1; k <= 5; k++) begin
         do_update(v);
         if (k == 4) chk("pre-lock state", 64'(state_out), 64'd1);
      end
      chk("lock state",  64'(state_out), 64'd2);
      chk("lock locked", 64'(locked),    64'd1);
      chk("lock coeff",  64'(coeff_out), 64'(TRK_C));
      chk("lock gain",   64'(gain_out),  64'h1000);

      // unlock: 3 big steps, one small step restarts the run, then 8 big steps
      for (int k = 0; k < 3; k++) begin
         v = v + 48'd1000;
         do_update(v);
      end
      v = v + 48'd100;
      do_update(v);
      for (int k = 0; k < 7; k++) begin
         v = v + 48'd1000;
         do_update(v);
      end
      chk("unlock run7 state", 64'(state_out), 64'd2);
      v = v + 48'd1000;
      do_update(v);
      chk("unlock state",  64'(state_out), 64'd1);
      chk("unlock locked", 64'(locked),    64'd0);
      chk("unlock coeff",  64'(coeff_out), 64'(ACQ_C));

      // relock: no load-only update this time, 4 settled updates suffice
      for (int k = 1; k <= 4; k++) begin
         do_update(v);
         if (k == 3) chk("relock k3 state", 64'(state_out), 64'd1);
      end
      chk("relock state",   64'(state_out),   64'd2);
      chk("relock timeout", 64'(acq_timeout), 64'd0);

      // hold from TRACK, in-hold update moves gain only, release returns to TRACK
      hold = 1'b1;
      tick();
      chk("hold state",  64'(state_out),     64'd3);
      chk("hold evo",    64'(err_valid_out), 64'd0);
      chk("hold locked", 64'(locked),        64'd0);
      do_update(48'h0000_2000_0000);
      chk("hold upd state", 64'(state_out), 64'd3);
      chk("hold upd gain",  64'(gain_out),  64'h2000);
      chk("hold upd sat",   64'(sat),       64'd0);
      chk("hold coeff",     64'(coeff_out), 64'(TRK_C));
      hold = 1'b0;
      tick();
      chk("unhold state",  64'(state_out),     64'd2);
      chk("unhold locked", 64'(locked),        64'd1);
      chk("unhold evo",    64'(err_valid_out), 64'd1);
      hold = 1'b1;
      tick();
      chk("hold2 state", 64'(state_out), 64'd3);
      enable = 1'b0;
      tick();
      chk("hold->idle state", 64'(state_out),     64'd0);
      chk("hold->idle coeff", 64'(coeff_out),     64'd0);
      chk("hold->idle evo",   64'(err_valid_out), 64'd0);
      hold = 1'b0;

      // acquisition timeout: lock never reached because every step exceeds 0
      enable = 1'b1;
      tick();
      chk("to acq state", 64'(state_out), 64'd1);
      for (int k = 1; k <= 16; k++) begin
         do_update(48'(k * 1000));
         if (k == 15) chk("timeout k15", 64'(acq_timeout), 64'd0);
      end
      chk("timeout k16", 64'(acq_timeout), 64'd1);
      chk("timeout gain", 64'(gain_out), 64'h0100);
      chk("timeout sat",  64'(sat),      64'd1);
      tick(); tick(); tick();
      chk("timeout sticky", 64'(acq_timeout), 64'd1);
      chk("timeout state",  64'(state_out),   64'd1);
      enable = 1'b0;
      tick();
      chk("timeout clr", 64'(acq_timeout), 64'd0);
      chk("timeout idle", 64'(state_out),  64'd0);

      // reset mid-ACQUIRE with an update in flight
      enable = 1'b1;
      tick();
      do_update(48'h0000_4000_0000);
      chk("pre-rst gain", 64'(gain_out), 64'h4000);
      err_valid_in = 1'b1;
      tick();
      err_valid_in = 1'b0;
      err_in = 48'h0000_3000_0000;
      rst = 1'b1;
      tick();
      chk_all_zero("midrst");
      rst = 1'b0;
      tick();
      chk("post-rst gvalid", 64'(gain_valid), 64'd0);
      chk("post-rst gain",   64'(gain_out),   64'd0);
      chk("post-rst state",  64'(state_out),  64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
